// File: rtl/issue_warp_scheduler.sv
// Per-warp issue arbiter: picks one eligible warp per cycle (round-robin with an
// age-based starvation override), pops its buffer, and presents the warp id to
// dispatch through a registered valid/ready stage. Also exports stall counters.
module issue_warp_scheduler #(
  parameter  int NUM_WARPS = 4,
  parameter  int AGE_MAX   = 15,
  parameter  int CTR_BITS  = 44,
  localparam int WID_BITS  = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_WARPS-1:0] req_valid,
  input  logic [NUM_WARPS-1:0] sb_ready,
  output logic [NUM_WARPS-1:0] req_ready,
  output logic                 disp_valid,
  output logic [WID_BITS-1:0]  disp_wid,
  input  logic                 disp_ready,
  output logic [CTR_BITS-1:0]  perf_scb_stalls,
  output logic [CTR_BITS-1:0]  perf_disp_stalls,
  output logic [CTR_BITS-1:0]  perf_starve_grants
);

  localparam logic [7:0] AGE_THR = 8'(AGE_MAX);

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] starved;
  logic [NUM_WARPS-1:0] cand;
  logic [NUM_WARPS-1:0] grant_oh;
  logic                 load_en;
  logic                 any_elig;
  logic                 grant_vld;
  logic                 grant_starve;
  logic                 found;
  logic [WID_BITS-1:0]  scan_idx;
  logic [WID_BITS-1:0]  grant_idx;

  logic                 disp_valid_q, disp_valid_d;
  logic [WID_BITS-1:0]  disp_wid_q, disp_wid_d;
  logic [WID_BITS-1:0]  rr_q, rr_d;
  logic [7:0]           age_q [NUM_WARPS];
  logic [7:0]           age_d [NUM_WARPS];
  logic [CTR_BITS-1:0]  scb_stalls_q, scb_stalls_d;
  logic [CTR_BITS-1:0]  disp_stalls_q, disp_stalls_d;
  logic [CTR_BITS-1:0]  starve_grants_q, starve_grants_d;

  assign eligible = req_valid & sb_ready;
  assign any_elig = |eligible;
  assign load_en  = !disp_valid_q || disp_ready;

  // A warp is starved once it has waited AGE_MAX cycles and is now eligible;
  // age keeps counting while scoreboard-blocked but only matters once eligible.
  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_starve
      assign starved[gi] = eligible[gi] && (age_q[gi] >= AGE_THR);
    end
  endgenerate

  // Circular first-match search from the RR pointer over starved warps if any, else eligible warps
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    cand      = (|starved) ? starved : eligible;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_q + WID_BITS'(i);
      if (!found && cand[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Grant qualification; pops are suppressed while reset is held
  always_comb begin
    grant_vld    = reset_n && load_en && any_elig;
    grant_starve = grant_vld && (|starved);
    grant_oh     = grant_vld ? (NUM_WARPS'(1) << grant_idx) : '0;
  end

  // Next state of the dispatch register, RR pointer and perf counters
  always_comb begin
    disp_valid_d    = disp_valid_q;
    disp_wid_d      = disp_wid_q;
    rr_d            = rr_q;
    scb_stalls_d    = scb_stalls_q;
    disp_stalls_d   = disp_stalls_q;
    starve_grants_d = starve_grants_q;
    if (load_en) begin
      disp_valid_d = any_elig;
      if (any_elig) begin
        disp_wid_d = grant_idx;
        rr_d       = grant_idx + WID_BITS'(1);
      end
    end
    if ((|req_valid) && !any_elig) scb_stalls_d = scb_stalls_q + CTR_BITS'(1);
    if (disp_valid_q && !disp_ready) disp_stalls_d = disp_stalls_q + CTR_BITS'(1);
    if (grant_starve) starve_grants_d = starve_grants_q + CTR_BITS'(1);
  end

  // Per-warp age: saturating count of consecutive waiting cycles without a grant
  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_age
      always_comb begin
        age_d[gi] = '0;
        if (req_valid[gi] && !grant_oh[gi]) begin
          age_d[gi] = (age_q[gi] == 8'hFF) ? age_q[gi] : age_q[gi] + 8'd1;
        end
      end

      // Age register
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) age_q[gi] <= '0;
        else          age_q[gi] <= age_d[gi];
      end
    end
  endgenerate

  // Dispatch stage, RR pointer and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_valid_q    <= 1'b0;
      disp_wid_q      <= '0;
      rr_q            <= '0;
      scb_stalls_q    <= '0;
      disp_stalls_q   <= '0;
      starve_grants_q <= '0;
    end else begin
      disp_valid_q    <= disp_valid_d;
      disp_wid_q      <= disp_wid_d;
      rr_q            <= rr_d;
      scb_stalls_q    <= scb_stalls_d;
      disp_stalls_q   <= disp_stalls_d;
      starve_grants_q <= starve_grants_d;
    end
  end

  // Output drive
  always_comb begin
    req_ready          = grant_oh;
    disp_valid         = disp_valid_q;
    disp_wid           = disp_wid_q;
    perf_scb_stalls    = scb_stalls_q;
    perf_disp_stalls   = disp_stalls_q;
    perf_starve_grants = starve_grants_q;
  end

endmodule
